board_move_engine: RTL



---
 rtl/board_move_engine.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/board_move_engine.sv
// Game-logic engine for the 4x4 sliding-tile board: slides/merges one line per cycle,
// spawns a random tile after a changing move and flags game over.
module board_move_engine #(
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int unsigned MAX_EXP = 15
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         move_valid,
    input  logic [1:0]   move_dir,
    output logic         move_ready,
    input  logic         new_game,
    output logic [0:255] board_state,
    output logic [31:0]  score,
    output logic         done,
    output logic         moved,
    output logic         game_over
);

    typedef enum logic [1:0] {StIdle, StLine, StSpawn, StCheck} state_e;
    typedef logic [3:0][3:0] line_t;
    typedef struct packed {
        line_t       tiles;
        logic [31:0] gain;
    } line_res_t;

    state_e           state_q, state_d;
    logic [15:0][3:0] board_q, board_d;
    logic [31:0]      score_q, score_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [1:0]       line_q, line_d;
    logic [1:0]       dir_q, dir_d;
    logic             changed_q, changed_d;
    logic             game_over_q, game_over_d;
    logic [3:0]       spawn_cnt_q, spawn_cnt_d;
    logic [3:0]       spawn_base_q, spawn_base_d;
    logic [1:0]       spawns_left_q, spawns_left_d;

    line_t            cur_line;
    line_res_t        res;
    logic [3:0]       spawn_idx;
    logic             spawn_fin;
    logic             can_play;
    logic             lfsr_fb;

    // Position 0 of every line is the edge the tiles slide toward.
    function automatic logic [3:0] tile_index(input logic [1:0] dir, input logic [1:0] line,
                                              input logic [1:0] pos);
        logic [3:0] idx;
        unique case (dir)
            2'd0:    idx = {line, pos};
            2'd1:    idx = {line, ~pos};
            2'd2:    idx = {pos, line};
            default: idx = {~pos, line};
        endcase
        return idx;
    endfunction

    function automatic line_res_t slide_line(input line_t in_line);
        logic [4:0][3:0] c;
        line_res_t       r;
        logic [2:0]      n;
        logic            skip;
        c    = '0;
        r    = '0;
        n    = '0;
        skip = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (in_line[2'(i)] != 4'd0) begin
                c[n] = in_line[2'(i)];
                n    = n + 3'd1;
            end
        end
        // c[4] stays zero, so the last compressed tile never finds a partner.
        n = '0;
        for (int i = 0; i < 4; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (c[3'(i)] != 4'd0) begin
                if (c[3'(i)] == c[3'(i + 1)] && c[3'(i)] != 4'(MAX_EXP)) begin
                    r.tiles[n[1:0]] = c[3'(i)] + 4'd1;
                    r.gain          = r.gain + (32'd1 << (c[3'(i)] + 4'd1));
                    skip            = 1'b1;
                end else begin
                    r.tiles[n[1:0]] = c[3'(i)];
                end
                n = n + 3'd1;
            end
        end
        return r;
    endfunction

    always_comb begin
        cur_line = '0;
        for (int p = 0; p < 4; p++) begin
            cur_line[2'(p)] = board_q[tile_index(dir_q, line_q, 2'(p))];
        end
    end

    assign res       = slide_line(cur_line);
    assign spawn_idx = (spawn_cnt_q == 4'd0) ? lfsr_q[3:0] : spawn_base_q + spawn_cnt_q;
    assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_comb begin
        logic [3:0] idx;
        can_play = 1'b0;
        idx      = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                idx = 4'(r * 4 + c);
                if (board_q[idx] == 4'd0) can_play = 1'b1;
                if (c < 3 && board_q[idx] == board_q[idx + 4'd1]) can_play = 1'b1;
                if (r < 3 && board_q[idx] == board_q[idx + 4'd4]) can_play = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        board_d       = board_q;
        score_d       = score_q;
        lfsr_d        = {lfsr_q[14:0], lfsr_fb};
        line_d        = line_q;
        dir_d         = dir_q;
        changed_d     = changed_q;
        game_over_d   = game_over_q;
        spawn_cnt_d   = spawn_cnt_q;
        spawn_base_d  = spawn_base_q;
        spawns_left_d = spawns_left_q;
        spawn_fin     = 1'b0;
        done          = 1'b0;
        moved         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (new_game) begin
                    board_d       = '0;
                    score_d       = '0;
                    game_over_d   = 1'b0;
                    changed_d     = 1'b1;
                    lfsr_d        = SEED;
                    spawns_left_d = 2'd2;
                    spawn_cnt_d   = '0;
                    state_d       = StSpawn;
                end else if (move_valid && !game_over_q) begin
                    dir_d     = move_dir;
                    line_d    = '0;
                    changed_d = 1'b0;
                    state_d   = StLine;
                end
            end
            StLine: begin
                for (int p = 0; p < 4; p++) begin
                    board_d[tile_index(dir_q, line_q, 2'(p))] = res.tiles[2'(p)];
                end
                score_d = score_q + res.gain;
                if (res.tiles != cur_line) changed_d = 1'b1;
                line_d = line_q + 2'd1;
                if (line_q == 2'd3) begin
                    spawns_left_d = 2'd1;
                    spawn_cnt_d   = '0;
                    state_d       = changed_d ? StSpawn : StCheck;
                end
            end
            StSpawn: begin
                if (spawn_cnt_q == 4'd0) spawn_base_d = lfsr_q[3:0];
                if (board_q[spawn_idx] == 4'd0) begin
                    board_d[spawn_idx] = (lfsr_q[15:12] == 4'd0) ? 4'd2 : 4'd1;
                    spawn_fin          = 1'b1;
                end else if (spawn_cnt_q == 4'd15) begin
                    spawn_fin = 1'b1;
                end else begin
                    spawn_cnt_d = spawn_cnt_q + 4'd1;
                end
                if (spawn_fin) begin
                    spawn_cnt_d = '0;
                    if (spawns_left_q > 2'd1) spawns_left_d = spawns_left_q - 2'd1;
                    else                      state_d       = StCheck;
                end
            end
            StCheck: begin
                done        = 1'b1;
                moved       = changed_q;
                game_over_d = !can_play;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q       <= StIdle;
            board_q       <= '0;
            score_q       <= '0;
            lfsr_q        <= SEED;
            line_q        <= '0;
            dir_q         <= '0;
            changed_q     <= 1'b0;
            game_over_q   <= 1'b0;
            spawn_cnt_q   <= '0;
            spawn_base_q  <= '0;
            spawns_left_q <= '0;
        end else begin
            state_q       <= state_d;
            board_q       <= board_d;
            score_q       <= score_d;
            lfsr_q        <= lfsr_d;
            line_q        <= line_d;
            dir_q         <= dir_d;
            changed_q     <= changed_d;
            game_over_q   <= game_over_d;
            spawn_cnt_q   <= spawn_cnt_d;
            spawn_base_q  <= spawn_base_d;
            spawns_left_q <= spawns_left_d;
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_board_out
        assign board_state[16*i +: 16] = {12'd0, board_q[i]};
    end

    assign move_ready = (state_q == StIdle) && !game_over_q;
    assign score      = score_q;
    assign game_over  = game_over_q;

endmodule
